// File: rtl/fb_pkg.sv
// Shared geometry, word layout and write-sequencer state encoding for the
// QVGA frame buffer controller.
package fb_pkg;

    localparam int C_IMG_COLS    = 320;
    localparam int C_IMG_ROWS    = 240;
    localparam int C_IMG_PXLS    = C_IMG_COLS * C_IMG_ROWS;
    localparam int C_NB_IMG_PXLS = 17;
    localparam int C_NB_COLS     = 10;
    localparam int C_NB_ROWS     = 10;

    localparam int C_NB_RED      = 4;
    localparam int C_NB_GREEN    = 4;
    localparam int C_NB_BLUE     = 4;
    localparam int C_NB_BUF      = C_NB_RED + C_NB_GREEN + C_NB_BLUE;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_FILL     = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fb_rd_addr.sv
// Display read path: row/col to linear RAM address, out-of-image blanking,
// and a two-stage valid/blank pipeline matched to the one-cycle RAM.
module fb_rd_addr
    import fb_pkg::*;
#(
    parameter int c_img_cols    = C_IMG_COLS,
    parameter int c_img_rows    = C_IMG_ROWS,
    parameter int c_nb_img_pxls = C_NB_IMG_PXLS,
    parameter int c_nb_cols     = C_NB_COLS,
    parameter int c_nb_rows     = C_NB_ROWS,
    parameter int c_nb_buf      = C_NB_BUF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     disp_en,
    input  logic [c_nb_cols-1:0]     disp_col,
    input  logic [c_nb_rows-1:0]     disp_row,
    input  logic [c_nb_buf-1:0]      doutb,
    output logic [c_nb_img_pxls-1:0] addrb,
    output logic                     disp_vld,
    output logic [c_nb_buf-1:0]      disp_rgb
);

    localparam logic [c_nb_cols-1:0]     col_lim   = c_nb_cols'(c_img_cols);
    localparam logic [c_nb_rows-1:0]     row_lim   = c_nb_rows'(c_img_rows);
    localparam logic [c_nb_img_pxls-1:0] row_pitch = c_nb_img_pxls'(c_img_cols);

    logic                     in_img;
    logic [c_nb_img_pxls-1:0] lin_addr;
    logic                     vld_q1;
    logic                     blank_q1;
    logic                     vld_q2;
    logic                     blank_q2;
    logic [c_nb_buf-1:0]      rgb_hold;

    always_comb begin
        in_img   = (disp_col < col_lim) && (disp_row < row_lim);
        lin_addr = c_nb_img_pxls'(disp_row) * row_pitch + c_nb_img_pxls'(disp_col);
    end

    // NOTE: clocked state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrb    <= '0;
            vld_q1   <= 1'b0;
            blank_q1 <= 1'b0;
            vld_q2   <= 1'b0;
            blank_q2 <= 1'b0;
            rgb_hold <= '0;
        end else begin
            vld_q1   <= disp_en;
            vld_q2   <= vld_q1;
            blank_q2 <= blank_q1;
            if (disp_en) begin
                addrb    <= in_img ? lin_addr : '0;
                blank_q1 <= !in_img;
            end
            if (vld_q2) begin
                rgb_hold <= disp_rgb;
            end
        end
    end

    // RAM data arrives in the same cycle as vld_q2; hold the last pixel otherwise.
    assign disp_vld = vld_q2;
    assign disp_rgb = !vld_q2 ? rgb_hold : (blank_q2 ? '0 : doutb);

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer sequencer: write port driven by camera capture or a colour
// fill engine, read port driven by display coordinates via fb_rd_addr.
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int c_img_cols    = C_IMG_COLS,
    parameter int c_img_rows    = C_IMG_ROWS,
    parameter int c_img_pxls    = c_img_cols * c_img_rows,
    parameter int c_nb_img_pxls = C_NB_IMG_PXLS,
    parameter int c_nb_cols     = C_NB_COLS,
    parameter int c_nb_rows     = C_NB_ROWS,
    parameter int c_nb_buf      = C_NB_BUF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cam_sof,
    input  logic                     cam_vld,
    input  logic [c_nb_buf-1:0]      cam_pxl,
    input  logic                     fill_req,
    input  logic [c_nb_buf-1:0]      fill_color,
    input  logic                     disp_en,
    input  logic [c_nb_cols-1:0]     disp_col,
    input  logic [c_nb_rows-1:0]     disp_row,
    output logic                     wea,
    output logic [c_nb_img_pxls-1:0] addra,
    output logic [c_nb_buf-1:0]      dina,
    output logic [c_nb_img_pxls-1:0] addrb,
    input  logic [c_nb_buf-1:0]      doutb,
    output logic                     disp_vld,
    output logic [c_nb_buf-1:0]      disp_rgb,
    output logic                     busy,
    output logic                     frame_done
);

    localparam logic [c_nb_img_pxls-1:0] last_addr = c_nb_img_pxls'(c_img_pxls - 1);
    localparam logic [c_nb_img_pxls-1:0] one_addr  = c_nb_img_pxls'(1);

    wr_state_e                state;
    wr_state_e                state_nxt;
    logic [c_nb_img_pxls-1:0] wr_cnt;
    logic [c_nb_img_pxls-1:0] wr_cnt_nxt;
    logic [c_nb_buf-1:0]      fill_q;
    logic                     fill_start;

    assign fill_start = (state == ST_WAIT_SOF) && !cam_sof && fill_req;
    assign busy       = (state == ST_FILL);

    // NOTE: every combinational output is defaulted first, so no branch infers a latch.
    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        wea        = 1'b0;
        addra      = '0;
        dina       = '0;
        frame_done = 1'b0;
        case (state)
            ST_WAIT_SOF: begin
                if (cam_sof) begin
                    state_nxt  = ST_CAPTURE;
                    wr_cnt_nxt = '0;
                end else if (fill_req) begin
                    state_nxt  = ST_FILL;
                    wr_cnt_nxt = '0;
                end
            end
            ST_CAPTURE: begin
                // A new SOF discards the partial frame; a coincident pixel lands at 0.
                if (cam_sof) begin
                    wr_cnt_nxt = '0;
                    if (cam_vld) begin
                        wea        = 1'b1;
                        dina       = cam_pxl;
                        wr_cnt_nxt = one_addr;
                    end
                end else if (cam_vld) begin
                    wea   = 1'b1;
                    addra = wr_cnt;
                    dina  = cam_pxl;
                    if (wr_cnt == last_addr) begin
                        frame_done = 1'b1;
                        state_nxt  = ST_WAIT_SOF;
                        wr_cnt_nxt = '0;
                    end else begin
                        wr_cnt_nxt = wr_cnt + 1'b1;
                    end
                end
            end
            ST_FILL: begin
                wea   = 1'b1;
                addra = wr_cnt;
                dina  = fill_q;
                if (wr_cnt == last_addr) begin
                    state_nxt  = ST_WAIT_SOF;
                    wr_cnt_nxt = '0;
                end else begin
                    wr_cnt_nxt = wr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = ST_WAIT_SOF;
                wr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_WAIT_SOF;
            wr_cnt <= '0;
            fill_q <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            if (fill_start) begin
                fill_q <= fill_color;
            end
        end
    end

    fb_rd_addr #(
        .c_img_cols    (c_img_cols),
        .c_img_rows    (c_img_rows),
        .c_nb_img_pxls (c_nb_img_pxls),
        .c_nb_cols     (c_nb_cols),
        .c_nb_rows     (c_nb_rows),
        .c_nb_buf      (c_nb_buf)
    ) u_rd_addr (
        .clk      (clk),
        .rst_n    (rst_n),
        .disp_en  (disp_en),
        .disp_col (disp_col),
        .disp_row (disp_row),
        .doutb    (doutb),
        .addrb    (addrb),
        .disp_vld (disp_vld),
        .disp_rgb (disp_rgb)
    );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a behavioural dual-port RAM model.
// Image height is reduced to 60 rows to keep full-frame runs short.
module tb_frame_buffer_ctrl;

    localparam int COLS = 320;
    localparam int ROWS = 60;
    localparam int PXLS = COLS * ROWS;
    localparam int NA   = 17;
    localparam int NB   = 12;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          cam_sof    = 1'b0;
    logic          cam_vld    = 1'b0;
    logic [NB-1:0] cam_pxl    = '0;
    logic          fill_req   = 1'b0;
    logic [NB-1:0] fill_color = '0;
    logic          disp_en    = 1'b0;
    logic [9:0]    disp_col   = '0;
    logic [9:0]    disp_row   = '0;
    logic          wea;
    logic [NA-1:0] addra;
    logic [NB-1:0] dina;
    logic [NA-1:0] addrb;
    logic [NB-1:0] doutb      = '0;
    logic          disp_vld;
    logic [NB-1:0] disp_rgb;
    logic          busy;
    logic          frame_done;

    logic [NB-1:0] mem [0:PXLS-1];

    int tests_run    = 0;
    int tests_failed = 0;
    int errs, fd_cnt, fd_at, busy_cnt, bad, hit;
    int rd_col [0:3];
    int rd_row [0:3];
    int rd_addr[0:3];
    int rd_rgb [0:3];

    frame_buffer_ctrl #(
        .c_img_cols    (COLS),
        .c_img_rows    (ROWS),
        .c_img_pxls    (PXLS),
        .c_nb_img_pxls (NA),
        .c_nb_cols     (10),
        .c_nb_rows     (10),
        .c_nb_buf      (NB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cam_sof    (cam_sof),
        .cam_vld    (cam_vld),
        .cam_pxl    (cam_pxl),
        .fill_req   (fill_req),
        .fill_color (fill_color),
        .disp_en    (disp_en),
        .disp_col   (disp_col),
        .disp_row   (disp_row),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .addrb      (addrb),
        .doutb      (doutb),
        .disp_vld   (disp_vld),
        .disp_rgb   (disp_rgb),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wea && addra < NA'(PXLS)) mem[addra] <= dina;
        if (addrb < NA'(PXLS)) doutb <= mem[addrb];
        else                   doutb <= '0;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue n back-to-back reads from rd_* tables, then check the held pixel.
    task automatic run_reads(input int n);
        for (int j = 0; j < n + 2; j++) begin
            if (j < n) begin
                disp_en  = 1'b1;
                disp_col = 10'(rd_col[j]);
                disp_row = 10'(rd_row[j]);
            end else begin
                disp_en = 1'b0;
            end
            @(negedge clk);
            if (j >= 1 && j <= n) check($sformatf("rd_addrb_%0d", j - 1), addrb, rd_addr[j - 1]);
            if (j >= 2) begin
                check($sformatf("rd_vld_%0d", j - 2), disp_vld, 1);
                check($sformatf("rd_rgb_%0d", j - 2), disp_rgb, rd_rgb[j - 2]);
            end
            next_cycle();
        end
        @(negedge clk);
        check("rd_idle_vld", disp_vld, 0);
        check("rd_hold_rgb", disp_rgb, rd_rgb[n - 1]);
        next_cycle();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wea", wea, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_addrb", addrb, 0);
        check("rst_disp_vld", disp_vld, 0);
        check("rst_disp_rgb", disp_rgb, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        next_cycle();
        rst_n = 1'b1;

        // Full camera frame, pixel value = address[11:0].
        cam_sof = 1'b1;
        next_cycle();
        cam_sof = 1'b0;
        errs = 0; fd_cnt = 0; fd_at = -1;
        for (int i = 0; i < PXLS; i++) begin
            cam_vld = 1'b1;
            cam_pxl = NB'(i);
            @(negedge clk);
            if (!wea || addra !== NA'(i) || dina !== NB'(i)) errs++;
            if (frame_done) begin fd_cnt++; fd_at = i; end
            next_cycle();
        end
        cam_pxl = 12'h555;
        @(negedge clk);
        check("cap_write_errs", errs, 0);
        check("cap_frame_done_cnt", fd_cnt, 1);
        check("cap_frame_done_at", fd_at, PXLS - 1);
        check("wait_sof_vld_ignored", wea, 0);
        next_cycle();
        cam_vld = 1'b0;

        // Reads over captured data: in-image, col out, row out, last pixel.
        rd_col  = '{5, 320, 0, 319};
        rd_row  = '{2, 0, 60, 59};
        rd_addr = '{645, 0, 0, 19199};
        rd_rgb  = '{12'h285, 0, 0, 12'hAFF};
        run_reads(4);

        // Aborted frame: SOF with pixel after 100 pixels restarts at 0.
        cam_sof = 1'b1;
        next_cycle();
        cam_sof = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cam_vld = 1'b1;
            cam_pxl = NB'(12'h100 + i);
            next_cycle();
        end
        cam_sof = 1'b1;
        cam_pxl = 12'hABC;
        @(negedge clk);
        check("abort_wea", wea, 1);
        check("abort_addra", addra, 0);
        check("abort_dina", dina, 12'hABC);
        check("abort_no_done", frame_done, 0);
        next_cycle();
        cam_sof = 1'b0;
        cam_pxl = 12'hABD;
        @(negedge clk);
        check("abort_next_addra", addra, 1);
        next_cycle();
        cam_vld    = 1'b0;
        fill_req   = 1'b1;
        fill_color = 12'h00F;
        next_cycle();
        fill_req = 1'b0;
        @(negedge clk);
        check("capture_fill_dropped", busy, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_capture_wea", wea, 0);
        next_cycle();
        rst_n = 1'b1;

        // Full fill with a stray SOF+pixel in the middle.
        fill_req   = 1'b1;
        fill_color = 12'hF00;
        @(negedge clk);
        check("fill_req_cycle_busy", busy, 0);
        next_cycle();
        fill_req = 1'b0;
        busy_cnt = 0; errs = 0; fd_cnt = 0;
        for (int k = 0; k < PXLS + 100; k++) begin
            cam_sof = (k == 500);
            cam_vld = (k == 500);
            cam_pxl = 12'h0AA;
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (!busy) break;
            busy_cnt++;
            if (!wea || addra !== NA'(k) || dina !== 12'hF00) errs++;
            next_cycle();
        end
        cam_sof = 1'b0;
        cam_vld = 1'b0;
        check("fill_busy_cycles", busy_cnt, PXLS);
        check("fill_write_errs", errs, 0);
        check("fill_no_done", fd_cnt, 0);
        next_cycle();
        bad = 0;
        for (int a = 0; a < PXLS; a++) if (mem[a] !== 12'hF00) bad++;
        check("fill_mem_content", bad, 0);

        rd_col  = '{5, 320, 0, 0};
        rd_row  = '{2, 0, 0, 0};
        rd_addr = '{645, 0, 0, 0};
        rd_rgb  = '{12'hF00, 0, 0, 0};
        run_reads(2);
        run_reads(1);

        // Reset at fill address 1000, then fill restarts from 0.
        fill_req   = 1'b1;
        fill_color = 12'h0F0;
        next_cycle();
        fill_req = 1'b0;
        hit = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (addra == NA'(1000)) begin hit = 1; break; end
            next_cycle();
        end
        check("mid_fill_reached", hit, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_fill_wea", wea, 0);
        check("rst_fill_addra", addra, 0);
        check("rst_fill_dina", dina, 0);
        check("rst_fill_busy", busy, 0);
        check("rst_fill_frame_done", frame_done, 0);
        check("rst_fill_addrb", addrb, 0);
        check("rst_fill_disp_vld", disp_vld, 0);
        check("rst_fill_disp_rgb", disp_rgb, 0);
        next_cycle();
        rst_n    = 1'b1;
        fill_req = 1'b1;
        next_cycle();
        fill_req = 1'b0;
        @(negedge clk);
        check("refill_busy", busy, 1);
        check("refill_addra", addra, 0);
        check("refill_dina", dina, 12'h0F0);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;

        // SOF and fill request together: capture wins.
        cam_sof    = 1'b1;
        fill_req   = 1'b1;
        fill_color = 12'hFFF;
        next_cycle();
        cam_sof  = 1'b0;
        fill_req = 1'b0;
        cam_vld  = 1'b1;
        cam_pxl  = 12'h123;
        @(negedge clk);
        check("sof_wins_busy", busy, 0);
        check("sof_wins_wea", wea, 1);
        check("sof_wins_addra", addra, 0);
        check("sof_wins_dina", dina, 12'h123);
        next_cycle();
        cam_vld = 1'b0;
        @(negedge clk);
        check("sof_wins_busy_later", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Sequences the QVGA frame buffer RAM: owns its write port (camera capture or internal fill engine) and its read port (display address generation with out-of-image blanking). Sits between the camera capture front end, the VGA timing generator and the `frame_buffer` instance, one clock domain.

## Interface

Parameters:
- `c_img_cols`, 320, image width in pixels
- `c_img_rows`, 240, image height in pixels
- `c_img_pxls`, `c_img_cols*c_img_rows`, pixels per frame
- `c_nb_img_pxls`, 17, buffer address width
- `c_nb_cols`, 10, display column input width
- `c_nb_rows`, 10, display row input width
- `c_nb_buf`, 12, pixel word width (4:4:4 RGB)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `cam_sof`  in  1  one-cycle start-of-frame pulse from capture
- `cam_vld`  in  1  `cam_pxl` valid this cycle
- `cam_pxl`  in  `c_nb_buf`  captured pixel
- `fill_req`  in  1  one-cycle request to fill the buffer with `fill_color`
- `fill_color`  in  `c_nb_buf`  fill value, sampled with `fill_req`
- `disp_en`  in  1  display requests a pixel this cycle
- `disp_col`  in  `c_nb_cols`  requested column
- `disp_row`  in  `c_nb_rows`  requested row
- `wea`  out  1  RAM write enable
- `addra`  out  `c_nb_img_pxls`  RAM write address
- `dina`  out  `c_nb_buf`  RAM write data
- `addrb`  out  `c_nb_img_pxls`  RAM read address (registered)
- `doutb`  in  `c_nb_buf`  RAM read data (1-cycle RAM latency)
- `disp_vld`  out  1  `disp_rgb` valid
- `disp_rgb`  out  `c_nb_buf`  pixel to display, 0 outside the image
- `busy`  out  1  state is FILL
- `frame_done`  out  1  one-cycle pulse: last pixel of a frame written

## Operation

- Write FSM states: WAIT_SOF, CAPTURE, FILL. Reset state WAIT_SOF.
- WAIT_SOF: `cam_vld` ignored. `cam_sof` -> CAPTURE, write counter := 0. `fill_req` -> FILL, counter := 0, colour latched.
- CAPTURE: each `cam_vld` cycle drives `wea`=1, `addra`=counter, `dina`=`cam_pxl`, counter+1. Write at address `c_img_pxls-1` pulses `frame_done` and -> WAIT_SOF. `cam_sof` in CAPTURE restarts at 0 (short frame discarded, no `frame_done`). `fill_req` in CAPTURE is dropped.
- FILL: `wea`=1 every cycle, `addra`=counter, `dina`=latched colour; after address `c_img_pxls-1` -> WAIT_SOF. `cam_sof`, `cam_vld`, `fill_req` ignored. No `frame_done`.
- `cam_sof` and `fill_req` in the same WAIT_SOF cycle: `cam_sof` wins.
- `cam_sof` with `cam_vld` in the same cycle: that pixel is written at address 0.
- Write counter never exceeds `c_img_pxls-1`; no wrap inside a frame.
- Read path is independent of the FSM (true dual port). Address = `disp_row*c_img_cols + disp_col`, computed with a constant multiplier. Out of image (`disp_col>=c_img_cols` or `disp_row>=c_img_rows`): `addrb`=0, blank flag set.

## Timing

- Write port outputs are combinational from state/counter/inputs. `wea`=0 in WAIT_SOF and whenever `cam_vld`=0 in CAPTURE.
- Read latency 2: `disp_en` at cycle t -> `addrb` registered at t+1 -> `disp_vld`=1, `disp_rgb` at t+2. Back-to-back requests give one pixel per cycle.
- `disp_rgb` = `doutb`, or 0 when the blank flag piped alongside is set. `disp_rgb` holds its value when `disp_vld`=0.
- Reset (async, any time, including mid-FILL or mid-CAPTURE): state WAIT_SOF, counter 0, `addrb` 0, pipeline valid/blank cleared. `wea`, `addra`, `dina`, `disp_vld`, `disp_rgb`, `busy`, `frame_done` are all 0. A partial frame is not resumed.
- `busy` is registered with the state: 1 from the cycle after `fill_req` through the last fill write.

## Structure

- Package `fb_pkg`: image geometry, address width, RGB field widths, and write-FSM state enum.
- One sub-module: `fb_rd_addr` (row/col to address, range check, 2-stage valid/blank pipeline). The write FSM stays in the top.
- The top does not instantiate `frame_buffer`; the integrator connects the two.

## Test plan

- Reset then `cam_sof` plus 76800 `cam_vld` pixels (value = address[11:0]) -> 76800 writes at addresses 0..76799, a single `frame_done` on the last write, state back to WAIT_SOF.
- `cam_sof` after 100 pixels -> pixel 101 written at address 0, no `frame_done` for the aborted frame.
- `fill_req` with `fill_color`=12'hF00 -> `busy` high for 76800 cycles, every address written 12'hF00. A `cam_sof` during the fill causes no camera write.
- Read (col 5, row 2) after the fill -> `addrb`=645 at t+1, `disp_vld`=1 and `disp_rgb`=12'hF00 at t+2. Read (col 320, row 0) -> `disp_rgb`=0.
- Assert `rst_n` low mid-FILL at address 1000 -> all outputs 0 immediately. After release, `fill_req` restarts at address 0.
- `cam_sof` and `fill_req` in the same cycle -> CAPTURE entered, fill dropped, `busy` stays 0.
